alarm_clock_core: RTL and testbench



---
 rtl/alarm_clock_core.sv | 172 +++++++++++++++++
 tb/tb_alarm_clock_core.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_core.sv
// Alarm clock core: free-running hours:minutes timekeeper, alarm register,
// ring/snooze/auto-shutoff state machine and a registered display mux.
module alarm_clock_core #(
  parameter int TICK_DIV   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic [4:0] hour_in,
  input  logic [5:0] min_in,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  input  logic       show_a,
  output logic [4:0] disp_hour,
  output logic [5:0] disp_min,
  output logic       sound_alarm,
  output logic       snoozing
);

  localparam int              PW          = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [5:0]      SNOOZE_LOAD = 6'(SNOOZE_MIN);
  localparam logic [5:0]      RING_LAST   = 6'(RING_MIN);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RINGING  = 2'd1,
    SNOOZING = 2'd2
  } state_t;

  logic [PW-1:0] presc_reg, presc_next;
  logic [4:0]    hour_reg, hour_next;
  logic [5:0]    min_reg, min_next;
  logic [4:0]    alarm_hour_reg, alarm_hour_next;
  logic [5:0]    alarm_min_reg, alarm_min_next;
  logic          tick_reg, match_reg;
  state_t        state_reg, state_next;
  logic [5:0]    ring_cnt_reg, ring_cnt_next;
  logic [5:0]    snooze_cnt_reg, snooze_cnt_next;
  logic [4:0]    disp_hour_reg;
  logic [5:0]    disp_min_reg;
  logic          sound_reg, snoozing_reg;

  logic          time_load, alarm_load, tick, match;
  logic [4:0]    inc_hour;
  logic [5:0]    inc_min;

  // Out-of-range loads are dropped as a whole, including the prescaler clear.
  assign time_load  = set_time  && (hour_in <= 5'd23) && (min_in <= 6'd59);
  assign alarm_load = set_alarm && (hour_in <= 5'd23) && (min_in <= 6'd59);
  assign tick       = (presc_reg == PRESC_LAST) && !time_load;

  always_comb begin
    inc_min  = min_reg + 6'd1;
    inc_hour = hour_reg;
    if (min_reg == 6'd59) begin
      inc_min  = 6'd0;
      inc_hour = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
    end
  end

  assign match = tick && (inc_hour == alarm_hour_reg) && (inc_min == alarm_min_reg);

  always_comb begin
    presc_next      = presc_reg + PW'(1);
    hour_next       = hour_reg;
    min_next        = min_reg;
    alarm_hour_next = alarm_hour_reg;
    alarm_min_next  = alarm_min_reg;
    if (time_load || (presc_reg == PRESC_LAST)) begin
      presc_next = '0;
    end
    if (time_load) begin
      hour_next = hour_in;
      min_next  = min_in;
    end else if (tick) begin
      hour_next = inc_hour;
      min_next  = inc_min;
    end
    if (alarm_load) begin
      alarm_hour_next = hour_in;
      alarm_min_next  = min_in;
    end
  end

  // The state machine acts on tick/match one cycle late so that the ring
  // starts on the same edge the display first shows the matching minute.
  always_comb begin
    state_next      = state_reg;
    ring_cnt_next   = ring_cnt_reg;
    snooze_cnt_next = snooze_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (match_reg && alarm_en) begin
          state_next    = RINGING;
          ring_cnt_next = 6'd0;
        end
      end
      RINGING: begin
        if (stop || !alarm_en) begin
          state_next = IDLE;
        end else if (snooze) begin
          state_next      = SNOOZING;
          snooze_cnt_next = SNOOZE_LOAD;
        end else if (tick_reg) begin
          ring_cnt_next = ring_cnt_reg + 6'd1;
          if (ring_cnt_reg + 6'd1 == RING_LAST) begin
            state_next = IDLE;
          end
        end
      end
      SNOOZING: begin
        if (stop || !alarm_en) begin
          state_next = IDLE;
        end else if (tick_reg) begin
          snooze_cnt_next = snooze_cnt_reg - 6'd1;
          if (snooze_cnt_reg == 6'd1) begin
            state_next    = RINGING;
            ring_cnt_next = 6'd0;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg      <= '0;
      hour_reg       <= 5'd0;
      min_reg        <= 6'd0;
      alarm_hour_reg <= 5'd0;
      alarm_min_reg  <= 6'd0;
      tick_reg       <= 1'b0;
      match_reg      <= 1'b0;
      state_reg      <= IDLE;
      ring_cnt_reg   <= 6'd0;
      snooze_cnt_reg <= 6'd0;
      disp_hour_reg  <= 5'd0;
      disp_min_reg   <= 6'd0;
      sound_reg      <= 1'b0;
      snoozing_reg   <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      hour_reg       <= hour_next;
      min_reg        <= min_next;
      alarm_hour_reg <= alarm_hour_next;
      alarm_min_reg  <= alarm_min_next;
      tick_reg       <= tick;
      match_reg      <= match;
      state_reg      <= state_next;
      ring_cnt_reg   <= ring_cnt_next;
      snooze_cnt_reg <= snooze_cnt_next;
      disp_hour_reg  <= show_a ? alarm_hour_reg : hour_reg;
      disp_min_reg   <= show_a ? alarm_min_reg : min_reg;
      sound_reg      <= (state_next == RINGING);
      snoozing_reg   <= (state_next == SNOOZING);
    end
  end

  assign disp_hour   = disp_hour_reg;
  assign disp_min    = disp_min_reg;
  assign sound_alarm = sound_reg;
  assign snoozing    = snoozing_reg;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Bench for alarm_clock_core: directed vector table, hand sequences for reset
// and ringing, then random stimulus against a minutes-of-day reference model.
module tb_alarm_clock_core;

  localparam int TD = 4;
  localparam int SN = 2;
  localparam int RM = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_time = 1'b0, set_alarm = 1'b0;
  logic [4:0] hour_in = 5'd0;
  logic [5:0] min_in = 6'd0;
  logic       alarm_en = 1'b0, snooze = 1'b0, stop = 1'b0, show_a = 1'b0;
  logic [4:0] disp_hour;
  logic [5:0] disp_min;
  logic       sound_alarm, snoozing;

  always #5 clk = ~clk;

  alarm_clock_core #(.TICK_DIV(TD), .SNOOZE_MIN(SN), .RING_MIN(RM)) dut (
    .clk(clk), .rst_n(rst_n), .set_time(set_time), .set_alarm(set_alarm),
    .hour_in(hour_in), .min_in(min_in), .alarm_en(alarm_en), .snooze(snooze),
    .stop(stop), .show_a(show_a), .disp_hour(disp_hour), .disp_min(disp_min),
    .sound_alarm(sound_alarm), .snoozing(snoozing)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: time as minutes of day, alarm as minutes of day,
  // ring/snooze as remaining-minute countdowns.
  localparam int MODE_IDLE = 0, MODE_RING = 1, MODE_SNOOZE = 2;
  int m_phase, m_tod, m_alarm, m_mode, m_ring_left, m_snz_left;
  bit m_pend_tick, m_pend_match;
  int m_dh, m_dm;
  bit m_sound, m_snz;

  task automatic model_reset();
    m_phase = 0; m_tod = 0; m_alarm = 0; m_mode = MODE_IDLE;
    m_ring_left = 0; m_snz_left = 0; m_pend_tick = 0; m_pend_match = 0;
    m_dh = 0; m_dm = 0; m_sound = 0; m_snz = 0;
  endtask

  task automatic model_step(input bit st, input bit sa, input int h, input int m,
                            input bit en, input bit sz, input bit sp, input bit sh);
    bit lt, la, tk, mt;
    int nxt;
    lt = st && h < 24 && m < 60;
    la = sa && h < 24 && m < 60;
    tk = (m_phase == TD - 1) && !lt;
    case (m_mode)
      MODE_IDLE:
        if (m_pend_match && en) begin m_mode = MODE_RING; m_ring_left = RM; end
      MODE_RING:
        if (sp || !en) m_mode = MODE_IDLE;
        else if (sz) begin m_mode = MODE_SNOOZE; m_snz_left = SN; end
        else if (m_pend_tick) begin
          m_ring_left--;
          if (m_ring_left == 0) m_mode = MODE_IDLE;
        end
      default:
        if (sp || !en) m_mode = MODE_IDLE;
        else if (m_pend_tick) begin
          m_snz_left--;
          if (m_snz_left == 0) begin m_mode = MODE_RING; m_ring_left = RM; end
        end
    endcase
    nxt = (m_tod + 1) % 1440;
    mt = tk && (nxt == m_alarm);
    m_dh = sh ? m_alarm / 60 : m_tod / 60;
    m_dm = sh ? m_alarm % 60 : m_tod % 60;
    m_phase = lt ? 0 : (m_phase + 1) % TD;
    if (lt) m_tod = h * 60 + m;
    else if (tk) m_tod = nxt;
    if (la) m_alarm = h * 60 + m;
    m_pend_tick = tk;
    m_pend_match = mt;
    m_sound = (m_mode == MODE_RING);
    m_snz = (m_mode == MODE_SNOOZE);
  endtask

  task automatic cycle(input bit st, input bit sa, input int h, input int m,
                       input bit en, input bit sz, input bit sp, input bit sh);
    set_time = st; set_alarm = sa; hour_in = 5'(h); min_in = 6'(m);
    alarm_en = en; snooze = sz; stop = sp; show_a = sh;
    model_step(st, sa, h, m, en, sz, sp, sh);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_hour"}, int'(disp_hour), m_dh);
    check({tag, "_min"}, int'(disp_min), m_dm);
    check({tag, "_sound"}, int'(sound_alarm), int'(m_sound));
    check({tag, "_snoozing"}, int'(snoozing), int'(m_snz));
  endtask

  typedef struct {
    int rep;
    bit st, sa; int h, m; bit en, sz, sp, sh;
    int eh, em; bit es, ez;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input int rep, input bit st, input bit sa, input int h,
                              input int m, input bit en, input bit sz, input bit sp,
                              input bit sh, input int eh, input int em, input bit es,
                              input bit ez);
    vec_t v;
    v.rep = rep; v.st = st; v.sa = sa; v.h = h; v.m = m; v.en = en; v.sz = sz;
    v.sp = sp; v.sh = sh; v.eh = eh; v.em = em; v.es = es; v.ez = ez;
    vecs.push_back(v);
  endfunction

  initial begin
    //  rep st sa  h  m  en sz sp sh   eh em es ez
    add(1, 0, 1, 0, 1,   1, 0, 0, 0,  0, 0, 0, 0);   // alarm 00:01
    add(1, 1, 0, 0, 0,   1, 0, 0, 0,  0, 0, 0, 0);   // time 00:00, prescaler cleared
    add(4, 0, 0, 0, 0,   1, 0, 0, 0,  0, 0, 0, 0);
    add(4, 0, 0, 0, 0,   1, 0, 0, 0,  0, 1, 1, 0);   // ringing from the edge showing 00:01
    add(4, 0, 0, 0, 0,   1, 0, 0, 0,  0, 2, 1, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  0, 3, 0, 0);   // auto-shutoff after 8 cycles
    add(1, 0, 1, 0, 5,   1, 0, 0, 0,  0, 3, 0, 0);   // alarm 00:05
    add(2, 0, 0, 0, 0,   1, 0, 0, 0,  0, 3, 0, 0);
    add(4, 0, 0, 0, 0,   1, 0, 0, 0,  0, 4, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  0, 5, 1, 0);
    add(1, 0, 0, 0, 0,   1, 1, 0, 0,  0, 5, 0, 1);   // snooze, prescaler phase 1
    add(2, 0, 0, 0, 0,   1, 0, 0, 0,  0, 5, 0, 1);
    add(4, 0, 0, 0, 0,   1, 1, 0, 0,  0, 6, 0, 1);   // snooze while snoozing ignored
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  0, 7, 1, 0);   // ringing resumes after 7 cycles
    add(1, 0, 0, 0, 0,   1, 0, 1, 0,  0, 7, 0, 0);   // stop
    add(1, 0, 1, 0, 8,   1, 0, 0, 0,  0, 7, 0, 0);   // alarm 00:08
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  0, 7, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  0, 8, 1, 0);
    add(1, 0, 0, 0, 0,   1, 1, 0, 0,  0, 8, 0, 1);
    add(1, 0, 0, 0, 0,   0, 0, 0, 0,  0, 8, 0, 0);   // alarm_en low during snooze
    add(1, 0, 1, 7, 30,  1, 0, 0, 0,  0, 8, 0, 0);   // alarm 07:30
    add(1, 1, 0, 1, 2,   1, 0, 0, 0,  0, 9, 0, 0);   // time 01:02
    add(1, 0, 0, 0, 0,   1, 0, 0, 1,  7, 30, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  1, 2, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 1,  7, 30, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  1, 2, 0, 0);
    add(1, 1, 0, 24, 0,  1, 0, 0, 0,  1, 3, 0, 0);   // invalid hour ignored
    add(1, 0, 1, 12, 60, 1, 0, 0, 1,  7, 30, 0, 0);  // invalid minute ignored
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  1, 3, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  1, 3, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  1, 4, 0, 0);
    add(1, 1, 0, 7, 30,  1, 0, 0, 0,  1, 4, 0, 0);   // set_time onto the alarm
    add(4, 0, 0, 0, 0,   1, 0, 0, 0,  7, 30, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  7, 31, 0, 0);
    add(1, 1, 0, 23, 59, 1, 0, 0, 0,  7, 31, 0, 0);
    add(4, 0, 0, 0, 0,   1, 0, 0, 0,  23, 59, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  0, 0, 0, 0);   // 23:59 -> 00:00
    add(1, 1, 0, 5, 59,  1, 0, 0, 0,  0, 0, 0, 0);
    add(4, 0, 0, 0, 0,   1, 0, 0, 0,  5, 59, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0,  6, 0, 0, 0);   // 05:59 -> 06:00

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hour", int'(disp_hour), 0);
    check("rst_min", int'(disp_min), 0);
    check("rst_sound", int'(sound_alarm), 0);
    check("rst_snoozing", int'(snoozing), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        cycle(vecs[i].st, vecs[i].sa, vecs[i].h, vecs[i].m, vecs[i].en,
              vecs[i].sz, vecs[i].sp, vecs[i].sh);
        $display("vec %0d.%0d: disp %0d:%0d sound %0d snoozing %0d", i, r,
                 disp_hour, disp_min, sound_alarm, snoozing);
        check($sformatf("vec%0d_%0d_hour", i, r), int'(disp_hour), vecs[i].eh);
        check($sformatf("vec%0d_%0d_min", i, r), int'(disp_min), vecs[i].em);
        check($sformatf("vec%0d_%0d_sound", i, r), int'(sound_alarm), int'(vecs[i].es));
        check($sformatf("vec%0d_%0d_snoozing", i, r), int'(snoozing), int'(vecs[i].ez));
      end
    end

    // Ring, then show_a while ringing, then asynchronous reset mid-ring.
    begin
      int t;
      t = (m_tod + 1) % 1440;
      cycle(0, 1, t / 60, t % 60, 1, 0, 0, 0);
      check_model("arm");
      for (int i = 0; i < 3 * TD + 4 && !sound_alarm; i++) begin
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        check_model("wait_ring");
      end
      check("ring_seen", int'(sound_alarm), 1);
      cycle(0, 0, 0, 0, 1, 0, 0, 1);
      check_model("ring_show_a");
      check("ring_show_a_sound", int'(sound_alarm), 1);
      $display("ring with show_a: disp %0d:%0d sound %0d", disp_hour, disp_min, sound_alarm);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_hour", int'(disp_hour), 0);
      check("async_rst_min", int'(disp_min), 0);
      check("async_rst_sound", int'(sound_alarm), 0);
      check("async_rst_snoozing", int'(snoozing), 0);
      $display("async reset mid-ring: sound %0d snoozing %0d", sound_alarm, snoozing);
      model_reset();
      show_a = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 1; i <= TD + 1; i++) begin
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        check_model("post_rst");
        if (i == TD) check("first_tick_pre", int'(disp_min), 0);
        if (i == TD + 1) check("first_tick_post", int'(disp_min), 1);
      end
    end

    // Random stimulus against the model; loads often target the next minutes.
    for (int c = 0; c < 1500; c++) begin
      int r, h, m, t;
      bit st, sa, en, sz, sp, sh;
      r  = int'($urandom_range(0, 99));
      st = (r < 3);
      sa = (r >= 3 && r < 10);
      en = ($urandom_range(0, 49) != 0);
      sz = ($urandom_range(0, 19) == 0);
      sp = ($urandom_range(0, 79) == 0);
      sh = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        h = int'($urandom_range(0, 31));
        m = int'($urandom_range(0, 63));
      end else begin
        t = (m_tod + int'($urandom_range(1, 3))) % 1440;
        h = t / 60;
        m = t % 60;
      end
      cycle(st, sa, h, m, en, sz, sp, sh);
      check_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
